// File: rtl/sd_cmd_engine.sv
// SD command-line engine: SD clock divider, 48-bit command serialiser with CRC7,
// 48/136-bit response receiver with timeout/CRC/end-bit/index checks, enable/ack delivery.
// Optional receive CRC7 checker: define SDHOST_CMD_CRC_CHECK_EN to include it.
module sd_cmd_engine #(
  parameter int DIV_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             new_command,
  input  logic [5:0]       cmd_index,
  input  logic [31:0]      cmd_argument,
  input  logic [1:0]       response_type,
  input  logic             crc_check_enable,
  input  logic             index_check_enable,
  input  logic [TO_W-1:0]  timeout_value,
  input  logic             cmd_pin_in,
  output logic             cmd_pin_out,
  output logic             cmd_oe,
  output logic             sd_clk_out,
  output logic             busy,
  output logic [127:0]     response,
  output logic [3:0]       error_status,
  output logic             enable_response,
  input  logic             ack_response,
  output logic             enable_command_complete,
  input  logic             ack_command_complete
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_RSP, RECV, CHECK, RSP_HS, DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;
  logic [46:0]      tx_sr;     // frame bits 1..47, bit 0 (start) is driven on entry
  logic [5:0]       tx_cnt;
  logic [127:0]     rx_sr;     // last 128 received bits; enough for both frame lengths
  logic [7:0]       rx_cnt;
  logic [TO_W-1:0]  wait_cnt;
  logic [TO_W-1:0]  to_q;
  logic [5:0]       idx_q;
  logic [1:0]       rtype_q;
  logic             idx_en_q;

  logic             div_term;
  logic             rise_tick;
  logic             fall_tick;
  logic [6:0]       tx_crc;
  logic             rsp_long;
  logic [7:0]       rx_total;
  logic [TO_W-1:0]  wait_nxt;
  logic             crc_err;
  logic             idx_err;
  logic             end_err;

  // CRC7 (x^7 + x^3 + 1), MSB first, zero initial value
  function automatic logic [6:0] crc7_fn(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign div_term  = (div_cnt == div_q);
  assign rise_tick = (state != IDLE) && div_term && !sd_clk_out;
  assign fall_tick = (state != IDLE) && div_term &&  sd_clk_out;
  assign tx_crc    = crc7_fn({2'b01, cmd_index, cmd_argument});
  assign rsp_long  = (rtype_q == 2'b01);
  assign rx_total  = rsp_long ? 8'd136 : 8'd48;
  assign wait_nxt  = wait_cnt + TO_W'(1);
  assign end_err   = ~rx_sr[0];
  assign idx_err   = idx_en_q && (rx_sr[45:40] != idx_q);

`ifdef SDHOST_CMD_CRC_CHECK_EN
  logic crc_en_q;

  // Receive CRC enable is latched with the rest of the command
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_en_q <= 1'b0;
    end else if (state == IDLE && new_command) begin
      crc_en_q <= crc_check_enable;
    end
  end

  assign crc_err = crc_en_q && (rx_sr[7:1] != crc7_fn(rx_sr[47:8]));
`else
  logic crc_unused;
  assign crc_unused = crc_check_enable ^ (^rx_sr[7:1]);
  assign crc_err    = 1'b0;
`endif

  // Command FSM with SD clock divider, serialiser, receiver and handshakes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      div_cnt                 <= '0;
      div_q                   <= '0;
      sd_clk_out              <= 1'b0;
      cmd_pin_out             <= 1'b1;
      cmd_oe                  <= 1'b0;
      busy                    <= 1'b0;
      tx_sr                   <= '0;
      tx_cnt                  <= '0;
      rx_sr                   <= '0;
      rx_cnt                  <= '0;
      wait_cnt                <= '0;
      to_q                    <= '0;
      idx_q                   <= '0;
      rtype_q                 <= '0;
      idx_en_q                <= 1'b0;
      response                <= '0;
      error_status            <= '0;
      enable_response         <= 1'b0;
      enable_command_complete <= 1'b0;
    end else begin
      if (state != IDLE) begin
        if (div_term) begin
          div_cnt    <= '0;
          sd_clk_out <= ~sd_clk_out;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (new_command) begin
            div_q        <= clk_div;
            div_cnt      <= '0;
            idx_q        <= cmd_index;
            rtype_q      <= response_type;
            idx_en_q     <= index_check_enable;
            to_q         <= timeout_value;
            error_status <= '0;
            tx_sr        <= {1'b1, cmd_index, cmd_argument, tx_crc, 1'b1};
            tx_cnt       <= '0;
            wait_cnt     <= '0;
            cmd_oe       <= 1'b1;
            cmd_pin_out  <= 1'b0;
            busy         <= 1'b1;
            state        <= SEND;
          end
        end

        SEND: begin
          if (fall_tick) begin
            if (tx_cnt == 6'd47) begin
              cmd_oe      <= 1'b0;
              cmd_pin_out <= 1'b1;
              if (rtype_q == 2'b00) begin
                enable_command_complete <= 1'b1;
                state                   <= DONE;
              end else begin
                state <= WAIT_RSP;
              end
            end else begin
              tx_cnt      <= tx_cnt + 6'd1;
              cmd_pin_out <= tx_sr[46];
              tx_sr       <= {tx_sr[45:0], 1'b0};
            end
          end
        end

        WAIT_RSP: begin
          if (rise_tick) begin
            if (!cmd_pin_in) begin
              rx_sr  <= {rx_sr[126:0], 1'b0};
              rx_cnt <= 8'd1;
              state  <= RECV;
            end else begin
              wait_cnt <= wait_nxt;
              if (to_q != '0 && wait_nxt == to_q) begin
                error_status[0]         <= 1'b1;
                enable_command_complete <= 1'b1;
                state                   <= DONE;
              end
            end
          end
        end

        RECV: begin
          if (rise_tick) begin
            rx_sr  <= {rx_sr[126:0], cmd_pin_in};
            rx_cnt <= rx_cnt + 8'd1;
            if (rx_cnt + 8'd1 == rx_total) state <= CHECK;
          end
        end

        CHECK: begin
          if (rsp_long) begin
            response     <= {8'h00, rx_sr[127:8]};
            error_status <= {1'b0, end_err, 2'b00};
          end else begin
            response     <= {96'h0, rx_sr[39:8]};
            error_status <= {idx_err, end_err, crc_err, 1'b0};
          end
          enable_response <= 1'b1;
          state           <= RSP_HS;
        end

        RSP_HS: begin
          if (ack_response) begin
            enable_response         <= 1'b0;
            enable_command_complete <= 1'b1;
            state                   <= DONE;
          end
        end

        DONE: begin
          if (ack_command_complete) begin
            enable_command_complete <= 1'b0;
            busy                    <= 1'b0;
            div_cnt                 <= '0;
            sd_clk_out              <= 1'b0;
            state                   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: card model on the CMD line with a scoreboard of
// expected frames, responses and error codes, consumed as the DUT produces them.
module tb_sd_cmd_engine;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   clk_div = 8'd1;
  logic         new_command = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_argument = '0;
  logic [1:0]   response_type = '0;
  logic         crc_check_enable = 1'b0;
  logic         index_check_enable = 1'b0;
  logic [15:0]  timeout_value = '0;
  logic         cmd_pin_in = 1'b1;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         sd_clk_out;
  logic         busy;
  logic [127:0] response;
  logic [3:0]   error_status;
  logic         enable_response;
  logic         ack_response = 1'b0;
  logic         enable_command_complete;
  logic         ack_command_complete = 1'b0;

`ifdef SDHOST_CMD_CRC_CHECK_EN
  localparam logic [3:0] CRC_ERR = 4'b0010;
`else
  localparam logic [3:0] CRC_ERR = 4'b0000;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] last_resp = '0;

  logic [47:0]  exp_frame_q[$];
  logic [127:0] exp_rsp_q[$];
  logic [3:0]   exp_err_q[$];

  sd_cmd_engine #(.DIV_W(8), .TO_W(16)) dut (
    .clock(clock), .reset(reset), .clk_div(clk_div), .new_command(new_command),
    .cmd_index(cmd_index), .cmd_argument(cmd_argument), .response_type(response_type),
    .crc_check_enable(crc_check_enable), .index_check_enable(index_check_enable),
    .timeout_value(timeout_value), .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out),
    .cmd_oe(cmd_oe), .sd_clk_out(sd_clk_out), .busy(busy), .response(response),
    .error_status(error_status), .enable_response(enable_response),
    .ack_response(ack_response), .enable_command_complete(enable_command_complete),
    .ack_command_complete(ack_command_complete)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the next 0->1 transition of sd_clk_out, seen at negedge
  task automatic wait_sd_rise(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = sd_clk_out;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (!prev && sd_clk_out) begin
        ok = 1'b1;
        return;
      end
      prev = sd_clk_out;
    end
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic [7:0] div, input bit crc_en, input bit idx_en,
                        input logic [15:0] to, input logic [135:0] rbits, input int rlen,
                        input int rdelay, input logic [47:0] exp_frame, input bit exp_rsp,
                        input logic [127:0] exp_resp, input logic [3:0] exp_err,
                        input int exp_rises, input bit glitch);
    logic [47:0] frame;
    bit          ok;
    bit          oe_ok;
    logic        prev;
    int          rises;
    int          falls;
    int          bi;
    bit          seen;

    exp_frame_q.push_back(exp_frame);
    if (exp_rsp) exp_rsp_q.push_back(exp_resp);
    exp_err_q.push_back(exp_err);

    @(negedge clock);
    cmd_index = idx; cmd_argument = arg; response_type = rt; clk_div = div;
    crc_check_enable = crc_en; index_check_enable = idx_en; timeout_value = to;
    new_command = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    chk("busy_start", busy, 1'b1);

    // Capture the transmitted frame on SD clock rising edges
    frame = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      wait_sd_rise(ok);
      if (!ok) begin
        chk("tx_sdclk_timeout", 0, 1);
        return;
      end
      frame = {frame[46:0], cmd_pin_out};
      oe_ok = oe_ok & cmd_oe;
      if (glitch && i == 10) begin
        cmd_index   = 6'h3F;
        new_command = 1'b1;
        @(negedge clock);
        new_command = 1'b0;
      end
    end
    chk("tx_frame", frame, exp_frame_q.pop_front());
    chk("tx_oe", oe_ok, 1'b1);

    // Card side: drive reply bits on SD clock falling edges, wait for a handshake
    rises = 0; falls = 0; bi = 0; seen = 1'b0;
    prev  = sd_clk_out;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (prev && !sd_clk_out) begin
        falls++;
        if (falls > rdelay && bi < rlen) begin
          cmd_pin_in = rbits[rlen-1-bi];
          bi++;
        end else begin
          cmd_pin_in = 1'b1;
        end
      end
      if (!prev && sd_clk_out) rises++;
      prev = sd_clk_out;
      if (enable_response || enable_command_complete) begin
        seen = 1'b1;
        break;
      end
    end
    cmd_pin_in = 1'b1;
    if (!seen) begin
      chk("handshake_timeout", 0, 1);
      return;
    end
    chk("oe_released", {cmd_oe, cmd_pin_out}, 2'b01);
    if (exp_rises >= 0) chk("timeout_rises", rises, exp_rises);

    if (enable_response) begin
      if (exp_rsp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        last_resp = exp_rsp_q.pop_front();
        chk("response", response, last_resp);
      end
      chk("rsp_before_cc", enable_command_complete, 1'b0);
      ack_command_complete = 1'b1;      // early ack must be ignored
      @(negedge clock);
      ack_command_complete = 1'b0;
      chk("rsp_held", enable_response, 1'b1);
      ack_response = 1'b1;
      @(negedge clock);
      ack_response = 1'b0;
      chk("rsp_dropped", enable_response, 1'b0);
      for (int c = 0; c < 20 && !enable_command_complete; c++) @(negedge clock);
    end else if (exp_rsp) begin
      void'(exp_rsp_q.pop_front());
      chk("rsp_missing", 0, 1);
    end else begin
      chk("resp_unchanged", response, last_resp);
    end

    if (!enable_command_complete) begin
      chk("cc_timeout", 0, 1);
      return;
    end
    chk("err_status", error_status, exp_err_q.pop_front());
    chk("cc_busy", busy, 1'b1);
    repeat (3) @(negedge clock);
    chk("cc_held", enable_command_complete, 1'b1);
    ack_command_complete = 1'b1;
    @(negedge clock);
    ack_command_complete = 1'b0;
    chk("cc_dropped", enable_command_complete, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_sdclk", sd_clk_out, 1'b0);
    chk("resp_stable", response, last_resp);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clock);
    chk("rst_sdclk", sd_clk_out, 1'b0);
    chk("rst_pin", {cmd_pin_out, cmd_oe, busy}, 3'b100);
    chk("rst_resp", response, 128'h0);
    chk("rst_err", error_status, 4'h0);
    chk("rst_en", {enable_response, enable_command_complete}, 2'b00);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_sdclk0", sd_clk_out, 1'b0);

    // CMD0, no response
    do_cmd(6'd0, 32'h0, 2'b00, 8'd1, 1, 1, 16'd0, '0, 0, 0,
           48'h400000000095, 0, '0, 4'b0000, -1, 0);
    // CMD8, good R7 reply; a stray new_command during SEND is ignored
    do_cmd(6'd8, 32'h1AA, 2'b10, 8'd1, 1, 1, 16'd64, 136'h08000001AA13, 48, 2,
           48'h48000001AA87, 1, 128'h1AA, 4'b0000, -1, 1);
    // bad CRC
    do_cmd(6'd8, 32'h1AA, 2'b10, 8'd1, 1, 1, 16'd64, 136'h08000001AA15, 48, 1,
           48'h48000001AA87, 1, 128'h1AA, CRC_ERR, -1, 0);
    // wrong index
    do_cmd(6'd8, 32'h1AA, 2'b10, 8'd1, 0, 1, 16'd64, 136'h09000001AA13, 48, 0,
           48'h48000001AA87, 1, 128'h1AA, 4'b1000, -1, 0);
    // end bit 0
    do_cmd(6'd8, 32'h1AA, 2'b10, 8'd1, 1, 1, 16'd64, 136'h08000001AA12, 48, 3,
           48'h48000001AA87, 1, 128'h1AA, 4'b0100, -1, 0);
    // timeout after 16 SD clocks
    do_cmd(6'd8, 32'h1AA, 2'b10, 8'd1, 1, 1, 16'd16, '0, 0, 0,
           48'h48000001AA87, 0, '0, 4'b0001, 16, 0);
    // 136-bit response, different divider
    do_cmd(6'd2, 32'h0, 2'b01, 8'd2, 1, 1, 16'd0, {8'h3F, {15{8'hA5}}, 8'h01}, 136, 2,
           48'h42000000004D, 1, {8'h00, {15{8'hA5}}}, 4'b0000, -1, 0);
    // type 11, fastest divider
    do_cmd(6'd8, 32'h1AA, 2'b11, 8'd0, 1, 1, 16'd100, 136'h08000001AA13, 48, 1,
           48'h48000001AA87, 1, 128'h1AA, 4'b0000, -1, 0);

    // Reset in the middle of SEND
    @(negedge clock);
    cmd_index = 6'd8; cmd_argument = 32'h1AA; response_type = 2'b10; clk_div = 8'd1;
    new_command = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    for (int i = 0; i < 21; i++) wait_sd_rise(ok);
    chk("pre_rst_oe", cmd_oe, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_pins", {cmd_oe, cmd_pin_out, busy, sd_clk_out}, 4'b0100);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("midrst_no_hs", {enable_response, enable_command_complete, busy}, 3'b000);
    last_resp = '0;
    do_cmd(6'd0, 32'h0, 2'b00, 8'd1, 0, 0, 16'd0, '0, 0, 0,
           48'h400000000095, 0, '0, 4'b0000, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
Parametrised next-generation SD command-line engine, placed between the host register file (00Eh/008h/010h/030h/032h) and the CMD pin.
- Generates the SD clock from the system clock with a programmable divider.
- Serialises the 48-bit command frame with CRC7.
- Receives 48-bit or 136-bit responses, checks timeout/CRC/end-bit/index, and delivers results to the register file over enable/ack handshakes.

Parameters:
DIV_W, 8, width of the SD clock divider value
TO_W, 16, width of the response timeout counter (in SD clock periods)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
clk_div  input  DIV_W  SD clock half-period minus 1, in system clocks
new_command  input  1  one-cycle start pulse
cmd_index  input  6  command index
cmd_argument  input  32  command argument
response_type  input  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit (busy ignored)
crc_check_enable  input  1  enable CRC7 check of 48-bit responses
index_check_enable  input  1  enable index check of 48-bit responses
timeout_value  input  TO_W  response wait limit in SD clocks; 0 = no timeout
cmd_pin_in  input  1  CMD line from card
cmd_pin_out  output  1  CMD line to card
cmd_oe  output  1  CMD output enable
sd_clk_out  output  1  SD clock to card
busy  output  1  engine not IDLE
response  output  128  captured response
error_status  output  4  [0] timeout, [1] CRC, [2] end bit, [3] index
enable_response  output  1  response valid, held until ack
ack_response  input  1  register 010h accepted response
enable_command_complete  output  1  completion valid, held until ack
ack_command_complete  input  1  register 030h accepted completion

Behaviour:
- Reset values (asynchronous, while reset=0):
  - sd_clk_out=0, cmd_pin_out=1, cmd_oe=0, busy=0.
  - response=0, error_status=0, both enables=0, state IDLE, all counters 0.
  - Reset mid-operation aborts immediately; no handshake is issued afterwards.
- Divider:
  - Counter runs 0..clk_div. At the terminal count it wraps and toggles sd_clk_out. clk_div=0 gives clock/2.
  - fall_tick = toggle 1→0; rise_tick = toggle 0→1.
  - Divider runs only when not IDLE; sd_clk_out idles at 0.
  - clk_div is sampled at new_command and held for the whole command.
- Data timing: output bits change on fall_tick; input sampled on rise_tick.
- Start: new_command in IDLE latches cmd_index, cmd_argument, response_type, both check enables and timeout_value, clears error_status, and enters SEND. new_command outside IDLE is ignored.
- SEND:
  - cmd_oe=1. Shift frame MSB first: 0, 1, index[5:0], argument[31:0], CRC7[6:0], 1 (48 bits).
  - CRC7 polynomial x^7+x^3+1, computed over the first 40 bits.
  - After bit 47: cmd_oe=0, cmd_pin_out=1. Next state is WAIT_RSP, or DONE if response_type=00.
- WAIT_RSP:
  - On each rise_tick, cmd_pin_in=0 → RECV (start bit counted as bit 0).
  - Otherwise increment the wait counter. If timeout_value≠0 and counter==timeout_value → set error[0], go to DONE; response is unchanged.
- RECV:
  - Shift in the remaining 47 (48-bit) or 135 (136-bit) bits on rise_tick, then go to CHECK.
- CHECK (one system clock):
  - 48-bit: response[31:0]=frame[39:8], response[127:32]=0.
  - 48-bit: error[1] if crc_check_enable and frame[7:1]≠CRC7(frame[47:8]).
  - 48-bit: error[3] if index_check_enable and frame[45:40]≠latched index.
  - 136-bit: response[119:0]=frame[127:8], response[127:120]=0; no CRC or index check.
  - Both types: error[2] if last bit=0.
  - Then RSP_HS.
- RSP_HS: enable_response=1 until ack_response is sampled 1; deassert the next cycle, then go to DONE.
- DONE: enable_command_complete=1 until ack_command_complete is sampled 1; deassert, go to IDLE. busy falls in the same cycle.
- Ack asserted before its enable is ignored. response and error_status stay stable from CHECK until the next new_command.

Optional Feature:
SDHOST_CMD_CRC_CHECK_EN.
- Defined: CRC7 receive checker present; behaviour as above.
- Undefined: receive checker omitted; error[1] is forced to 0 and crc_check_enable is ignored.
- Transmit CRC7 is always present in both cases.

Test Plan:
- CMD0, arg 0, type 00, clk_div=1 → CMD line carries 0x400000000095. enable_response never asserts; enable_command_complete asserts; error_status=0.
- CMD8, arg 0x1AA, type 10, card replies 0x08000001AA13 → TX frame 0x48000001AA87; response=0x000001AA; error_status=0; response handshake completes before the completion handshake.
- Same as CMD8 but reply 0x08000001AA15 with CRC check on → error_status=4'b0010. Index 9 in reply with index check on → 4'b1000. Last bit 0 → 4'b0100.
- timeout_value=16, CMD line held 1 → error_status=4'b0001 after exactly 16 rise_ticks; no enable_response; completion asserted.
- Type 01, card returns 136 bits with payload 0x3F followed by 120 bits of 0xA5 → response[119:0]=all 0xA5 bytes, response[127:120]=0, no CRC error.
- reset=0 mid-SEND at bit 20 → cmd_oe=0, cmd_pin_out=1, busy=0 at once. A new command after release transmits a correct full frame.
